// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
package seven_seg_pkg;

    // All segments off (active-low encoding {g,f,e,d,c,b,a}).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low hex font, entry n is the segment pattern for nibble n.
    localparam logic [6:0] SEG_FONT [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Phase within one digit slot: blank dead time, then the PWM-lit part.
    typedef enum logic {
        PH_DEAD = 1'b0,
        PH_ON   = 1'b1
    } scan_phase_e;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low 7-segment pattern decoder.
module hex_to_seg7
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = SEG_FONT[nibble];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with shadow-buffered
// writes, frame-aligned swap, dead time, PWM brightness and leading-zero
// suppression. All display outputs are registered (one cycle of latency).
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 131072,
    parameter int DEAD     = 64,
    parameter int BRIGHT_W = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic [DIGITS-1:0]     wr_dp,
    input  logic                  wr_lz,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [DIGITS-1:0]     ca,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Scan counters
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [BRIGHT_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [BRIGHT_W-1:0] bright_q, bright_d;

    // Active (displayed) and shadow (pending) value registers
    logic [4*DIGITS-1:0] act_data_q, act_data_d;
    logic [DIGITS-1:0]   act_dp_q, act_dp_d;
    logic                act_lz_q, act_lz_d;
    logic [4*DIGITS-1:0] sh_data_q, sh_data_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
    logic                sh_lz_q, sh_lz_d;
    logic                pending_q, pending_d;

    // Registered pin drivers
    logic [DIGITS-1:0]   ca_q, ca_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic                frame_done_q, frame_done_d;

    logic                slot_end;
    logic                frame_end;
    logic                wr_accept;
    logic                swap;
    logic [BRIGHT_W-1:0] bright_eff;
    logic                lit;
    scan_phase_e         phase;
    logic [6:0]          digit_seg [DIGITS];
    logic [DIGITS-1:0]   supp;
    logic                zero_run;
    logic [6:0]          sel_seg;
    logic                sel_dp;
    logic                sel_supp;

    // One decoder per digit of the active register.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dec
            hex_to_seg7 u_dec (
                .nibble (act_data_q[4*gi +: 4]),
                .seg_n  (digit_seg[gi])
            );
        end
    endgenerate

    assign slot_end  = (cnt_q == CNT_W'(SCAN_DIV - 1));
    assign frame_end = slot_end && (idx_q == IDX_W'(DIGITS - 1));
    assign wr_accept = wr_valid && !pending_q;
    assign swap      = frame_end && pending_q;

    // Slot/digit/PWM counters; brightness is captured at slot start so the
    // duty cycle cannot change in the middle of a slot.
    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        pwm_cnt_d = pwm_cnt_q + BRIGHT_W'(1);
        bright_d  = bright_q;
        if (cnt_q == '0) begin
            bright_d = brightness;
        end
        if (slot_end) begin
            cnt_d     = '0;
            pwm_cnt_d = '0;
            idx_d     = frame_end ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Shadow buffer handshake and frame-boundary swap into the active register.
    always_comb begin
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_lz_d     = act_lz_q;
        sh_data_d    = sh_data_q;
        sh_dp_d      = sh_dp_q;
        sh_lz_d      = sh_lz_q;
        pending_d    = pending_q;
        frame_done_d = frame_end;
        if (swap) begin
            act_data_d = sh_data_q;
            act_dp_d   = sh_dp_q;
            act_lz_d   = sh_lz_q;
            pending_d  = 1'b0;
        end
        if (wr_accept) begin
            sh_data_d = wr_data;
            sh_dp_d   = wr_dp;
            sh_lz_d   = wr_lz;
            pending_d = 1'b1;
        end
    end

    // Leading-zero mask: a run of zero nibbles from the top digit down; digit 0 never blanks.
    always_comb begin
        supp     = '0;
        zero_run = act_lz_q;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (act_data_q[4*i +: 4] == 4'h0);
            supp[i]  = zero_run;
        end
    end

    // Next pin values from the current scan position (registered below).
    always_comb begin
        bright_eff = (cnt_q == '0) ? brightness : bright_q;
        phase      = (int'(cnt_q) < DEAD) ? PH_DEAD : PH_ON;
        lit        = (phase == PH_ON) && ((&bright_eff) || (pwm_cnt_q < bright_eff));
        sel_seg    = SEG_BLANK;
        sel_dp     = 1'b0;
        sel_supp   = 1'b0;
        ca_d       = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_seg  = digit_seg[i];
                sel_dp   = act_dp_q[i];
                sel_supp = supp[i];
                ca_d[i]  = !lit;
            end
        end
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (lit) begin
            seg_d = sel_supp ? SEG_BLANK : sel_seg;
            dp_d  = !sel_dp;
        end
    end

    // State and output registers; asynchronous reset drops any pending value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pwm_cnt_q    <= '0;
            bright_q     <= '0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_lz_q     <= 1'b0;
            sh_data_q    <= '0;
            sh_dp_q      <= '0;
            sh_lz_q      <= 1'b0;
            pending_q    <= 1'b0;
            ca_q         <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pwm_cnt_q    <= pwm_cnt_d;
            bright_q     <= bright_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_lz_q     <= act_lz_d;
            sh_data_q    <= sh_data_d;
            sh_dp_q      <= sh_dp_d;
            sh_lz_q      <= sh_lz_d;
            pending_q    <= pending_d;
            ca_q         <= ca_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wr_ready   = !pending_q;
    assign ca         = ca_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomised + directed bench for seven_seg_scan_ctrl against a cycle-count
// based reference model of the display behaviour.
module tb_seven_seg_scan_ctrl;

    localparam int D     = 3;
    localparam int SD    = 16;
    localparam int DD    = 2;
    localparam int BW    = 4;
    localparam int FRAME = D * SD;

    logic            clk;
    logic            resetn;
    logic            wr_valid;
    logic            wr_ready;
    logic [4*D-1:0]  wr_data;
    logic [D-1:0]    wr_dp;
    logic            wr_lz;
    logic [BW-1:0]   brightness;
    logic [D-1:0]    ca;
    logic [6:0]      seg;
    logic            dp;
    logic            frame_done;

    seven_seg_scan_ctrl #(
        .DIGITS   (D),
        .SCAN_DIV (SD),
        .DEAD     (DD),
        .BRIGHT_W (BW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .wr_lz      (wr_lz),
        .brightness (brightness),
        .ca         (ca),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: time since reset plus the displayed/pending values.
    int          t;
    logic [11:0] m_act, m_sh;
    logic [2:0]  m_act_dp, m_sh_dp;
    logic        m_act_lz, m_sh_lz, m_pend;
    logic [3:0]  m_bright;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        chk_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp_v, t);
        end
    endtask

    task automatic model_reset();
        t        = 0;
        m_act    = '0;
        m_sh     = '0;
        m_act_dp = '0;
        m_sh_dp  = '0;
        m_act_lz = 1'b0;
        m_sh_lz  = 1'b0;
        m_pend   = 1'b0;
        m_bright = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ca"},  32'(ca), 32'h7);
        check({tag, "_seg"}, 32'(seg), 32'h7F);
        check({tag, "_dp"},  32'(dp), 32'h1);
        check({tag, "_rdy"}, 32'(wr_ready), 32'h1);
        check({tag, "_fd"},  32'(frame_done), 32'h0);
    endtask

    // One clock: predict the pins from the pre-edge scan position, then compare.
    task automatic step();
        int         cnt, idx, pwm;
        logic [3:0] b, nib;
        logic       on, supp, accept, swap;
        logic [2:0] e_ca;
        logic [6:0] e_seg;
        logic       e_dp, e_fd;
        cnt    = t % SD;
        idx    = (t / SD) % D;
        pwm    = cnt % (1 << BW);
        b      = (cnt == 0) ? brightness : m_bright;
        on     = (cnt >= DD) && ((b == 4'hF) || (pwm < int'(b)));
        nib    = 4'((m_act >> (4 * idx)) & 12'hF);
        supp   = m_act_lz && (idx > 0) && ((m_act >> (4 * idx)) == 12'h0);
        e_ca   = 3'b111;
        e_seg  = 7'h7F;
        e_dp   = 1'b1;
        if (on) begin
            e_ca[idx] = 1'b0;
            e_seg     = supp ? 7'h7F : font[nib];
            e_dp      = !m_act_dp[idx];
        end
        e_fd   = ((t % FRAME) == FRAME - 1);
        accept = wr_valid && !m_pend;
        swap   = e_fd && m_pend;
        @(posedge clk);
        #1;
        if (swap) begin
            m_act    = m_sh;
            m_act_dp = m_sh_dp;
            m_act_lz = m_sh_lz;
            m_pend   = 1'b0;
            $display("swap   t=%0d active=%03h dp=%b lz=%b", t, m_act, m_act_dp, m_act_lz);
        end
        if (accept) begin
            m_sh    = wr_data;
            m_sh_dp = wr_dp;
            m_sh_lz = wr_lz;
            m_pend  = 1'b1;
            $display("write  t=%0d data=%03h dp=%b lz=%b", t, wr_data, wr_dp, wr_lz);
        end
        if (cnt == 0) m_bright = brightness;
        check("ca",         32'(ca), 32'(e_ca));
        check("seg",        32'(seg), 32'(e_seg));
        check("dp",         32'(dp), 32'(e_dp));
        check("frame_done", 32'(frame_done), 32'(e_fd));
        check("wr_ready",   32'(wr_ready), 32'(!m_pend));
        t++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the model is at the given position within the frame.
    task automatic run_to(input int frame_pos);
        for (int i = 0; i < FRAME && (t % FRAME) != frame_pos; i++) step();
    endtask

    task automatic offer(input logic [11:0] data, input logic [2:0] dpv, input logic lz);
        wr_valid = 1'b1;
        wr_data  = data;
        wr_dp    = dpv;
        wr_lz    = lz;
        step();
        wr_valid = 1'b0;
    endtask

    initial begin
        resetn     = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = '0;
        wr_dp      = '0;
        wr_lz      = 1'b0;
        brightness = 4'hF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        resetn = 1'b1;

        // Full brightness, default "000" for two frames.
        run(2 * FRAME);

        // Mid-frame write, then a second offer while pending that must be ignored.
        run_to(20);
        offer(12'h1A8, 3'b000, 1'b0);
        wr_valid = 1'b1;
        wr_data  = 12'h777;
        wr_dp    = 3'b111;
        run(6);
        wr_valid = 1'b0;
        run(2 * FRAME);

        // Leading-zero suppression with a dp on a suppressed digit.
        offer(12'h005, 3'b100, 1'b1);
        run(2 * FRAME + 4);

        // Reduced and zero brightness.
        brightness = 4'd4;
        run(2 * FRAME);
        brightness = 4'd0;
        run(FRAME);
        brightness = 4'hF;
        run(FRAME);

        // Randomised writes and brightness changes.
        for (int i = 0; i < 600; i++) begin
            wr_valid = ($urandom_range(5) == 0);
            wr_data  = 12'($urandom);
            if ($urandom_range(3) == 0) wr_data[11:4] = 8'h00;
            wr_dp    = 3'($urandom);
            wr_lz    = 1'($urandom);
            if ($urandom_range(39) == 0) brightness = 4'($urandom);
            step();
        end
        wr_valid   = 1'b0;
        brightness = 4'hF;
        run(FRAME);

        // Reset in the ON phase while a write is pending.
        run_to(5);
        offer(12'hBEE, 3'b011, 1'b0);
        run(SD + 2);
        check("pend_before_rst", 32'(wr_ready), 32'h0);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        check_reset_outputs("held_rst");
        resetn = 1'b1;
        model_reset();
        run(3 * FRAME);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
